jtkcpu_bussl: RTL and testbench
===============================

# jtkcpu_bussl

Bus responder for the jtkcpu memory bus. It decodes each 24-bit CPU access and routes it to internal RAM, to an external ROM request/acknowledge port, or to an I/O strobe port. It returns read data on the CPU `din` path and signals completion with `dtack`. It sits in the game top between the CPU and the SDRAM/ROM loader and the peripheral decode.

## Interface
Parameters:
- `RAM_AW`, 13, internal RAM address width (2^RAM_AW bytes).
- `IO_WAIT`, 2, extra cen ticks before an I/O access completes (0–15).
- `TOUT`, 255, cen ticks without `rom_ok` before a ROM access times out (1–255).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  clock enable; the FSM and counters advance only when `cen=1`.
- `as`  in  1  access strobe; the initiator holds it high until it sees `dtack`.
- `addr`  in  24  access address.
- `we`  in  1  1 means write.
- `cpu_dout`  in  8  write data from the CPU.
- `cpu_din`  out  8  read data to the CPU. Reset value 0.
- `dtack`  out  1  access complete. Reset value 0.
- `rom_cs`  out  1  ROM request. Reset value 0.
- `rom_addr`  out  22  ROM byte address. Reset value 0.
- `rom_data`  in  8  ROM read data.
- `rom_ok`  in  1  ROM data valid. The ROM source holds it until `rom_cs` falls.
- `io_cs`  out  1  one-clk I/O strobe. Reset value 0.
- `io_we`, `io_addr[7:0]`, `io_dout[7:0]`  out  I/O access qualifiers. Reset value 0.
- `io_din`  in  8  I/O read data.
- `bus_err`  out  1  one-clk pulse on an unmapped access or a ROM timeout. Reset value 0.

## Operation
Address decode uses `addr[23:22]`:
- `00`: ROM. A write to ROM is treated as unmapped.
- `01`: RAM, valid only when `addr[21:RAM_AW]==0`; otherwise unmapped.
- `10`: I/O, using `addr[7:0]`.
- `11`: unmapped.

FSM states: IDLE, RAM, ROM, IO, ERR, DONE.
- **IDLE**: on a cen tick with `as=1`, register `addr`, `we` and `cpu_dout`, then branch by decode.
- **RAM**:
  - A write is committed on the launch tick.
  - A read uses a synchronous port; data is latched into `cpu_din` on the next tick, then the FSM moves to DONE.
- **ROM**:
  - `rom_cs=1` and `rom_addr=addr[21:0]` from the launch tick onward.
  - On the first tick with `rom_ok=1`: latch `rom_data`, drop `rom_cs`, move to DONE.
  - The timeout counter (8 bits) counts ticks in ROM. At `TOUT` it forces `cpu_din=8'hFF`, drops `rom_cs`, pulses `bus_err`, and moves to DONE.
- **IO**:
  - `io_cs` is high for exactly one clk after the launch tick; `io_we`, `io_addr` and `io_dout` are held for the whole access.
  - The wait counter runs `IO_WAIT` ticks. On the final tick, a read latches `io_din` into `cpu_din`; then the FSM moves to DONE.
- **ERR** (unmapped): `cpu_din=8'hFF`, one-clk `bus_err` pulse, then DONE on the next tick. Writes are dropped.
- **DONE**: `dtack=1` while `as=1`. On the first cen tick with `as=0`, `dtack` falls and the FSM returns to IDLE.
  - A new access cannot launch on that same tick, so there is at least one IDLE tick between accesses.
- **Abort**: `as=0` in RAM, ROM or IO sends the FSM to IDLE with no `dtack`. `rom_cs` drops on that tick. A RAM or I/O write already issued is not undone.
- **Data hold**: `cpu_din` holds its last value outside reads; a write access leaves it unchanged.
- **Reset**: `rst_n=0` at any time clears every output and the FSM asynchronously, including mid-access. RAM contents are not cleared.

## Timing
T0 is the cen tick on which IDLE samples `as=1`. `dtack` rises at the clk edge of:
- **RAM** (read or write): T1.
- **Unmapped**: T1, with `bus_err` high during the clk after T0.
- **IO**: T(1+`IO_WAIT`).
- **ROM**: the first tick Tn (n≥1) with `rom_ok=1`, or T`TOUT` on timeout.

Additional timing rules:
- `rom_ok` is sampled only on cen ticks and is ignored outside the ROM state.
- With `cen=0` all state freezes. `io_cs` and `bus_err` pulses still last exactly one clk.
- `dtack` falls at the cen tick that samples `as=0` in DONE.

## Test plan
- **RAM round trip:** write 8'h5A to 24'h400123, then read it back → `dtack` at T1 for both accesses, `cpu_din=8'h5A`, no `bus_err`.
- **ROM with wait:** read 24'h012345 while `rom_ok` rises 4 ticks after `rom_cs` and `rom_data=8'hC3` →
  - `rom_addr=22'h012345`;
  - `dtack` at T4, `cpu_din=8'hC3`;
  - `rom_cs` low after T4.
- **ROM timeout:** `TOUT=8`, `rom_ok` never asserted → at T8 `cpu_din=8'hFF`, a 1-clk `bus_err` pulse, `dtack` high, `rom_cs` low.
- **I/O read and write:** `IO_WAIT=2`.
  - Read of 24'h800010 with `io_din=8'h77` → single-clk `io_cs`, `io_addr=8'h10`, `dtack` at T3, `cpu_din=8'h77`.
  - Write of 8'h11 → `io_we=1`, `io_dout=8'h11`.
- **Unmapped and ROM write:** a read of 24'hC00000, then a write to 24'h000010 →
  - each access gets `dtack` at T1 and a 1-clk `bus_err`;
  - the read returns `cpu_din=8'hFF`;
  - `rom_cs` stays 0 throughout.
- **Abort and reset:**
  - Drop `as` at T2 of a ROM access → `rom_cs` low and no `dtack`; the next access launches correctly.
  - Assert `rst_n=0` mid-IO → all outputs 0 immediately.
  - After reset release, a RAM read completes at T1.

Source files
------------

// File: rtl/jtkcpu_bussl.sv
// Bus responder for the jtkcpu memory bus: decodes each CPU access and routes it
// to internal RAM, the external ROM request port or the I/O strobe port.
module jtkcpu_bussl #(
  parameter int RAM_AW  = 13,
  parameter int IO_WAIT = 2,
  parameter int TOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        as,
  input  logic [23:0] addr,
  input  logic        we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        dtack,
  output logic        rom_cs,
  output logic [21:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic        io_cs,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, RAM, ROM, IO, ERR, DONE} state_t;

  localparam logic [7:0] TOUT_C = 8'(TOUT);
  localparam logic [3:0] WAIT_C = 4'(IO_WAIT);

  state_t      st, st_nx;
  logic        launch, fin, tout;
  logic        we_q;
  logic [7:0]  tcnt, tcnt_inc;
  logic [3:0]  wcnt;
  logic [7:0]  ram_q;
  logic [7:0]  mem [2**RAM_AW];
  logic        sel_ram, sel_rom, sel_io;

  // ROM writes fall through to the unmapped branch
  assign sel_rom  = (addr[23:22] == 2'b00) && !we;
  assign sel_ram  = (addr[23:22] == 2'b01) && (addr[21:RAM_AW] == '0);
  assign sel_io   = (addr[23:22] == 2'b10);
  assign tcnt_inc = tcnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;

  always_comb begin
    st_nx  = st;
    launch = 1'b0;
    fin    = 1'b0;
    tout   = 1'b0;
    if (cen) begin
      case (st)
        IDLE: if (as) begin
          launch = 1'b1;
          if      (sel_ram) st_nx = RAM;
          else if (sel_rom) st_nx = ROM;
          else if (sel_io)  st_nx = IO;
          else              st_nx = ERR;
        end
        RAM: if (!as) st_nx = IDLE;
             else begin fin = 1'b1; st_nx = DONE; end
        ROM: if (!as) st_nx = IDLE;
             else if (rom_ok) begin fin = 1'b1; st_nx = DONE; end
             else if (tcnt_inc == TOUT_C) begin tout = 1'b1; st_nx = DONE; end
        IO:  if (!as) st_nx = IDLE;
             else if (wcnt == WAIT_C) begin fin = 1'b1; st_nx = DONE; end
        ERR: begin fin = 1'b1; st_nx = DONE; end
        DONE: if (!as) st_nx = IDLE;
        default: st_nx = IDLE;
      endcase
    end
  end

  // RAM contents survive reset; the read is issued on the launch tick
  always_ff @(posedge clk)
    if (launch && st_nx == RAM) begin
      if (we) mem[addr[RAM_AW-1:0]] <= cpu_dout;
      ram_q <= mem[addr[RAM_AW-1:0]];
    end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_din  <= 8'd0;
      dtack    <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 22'd0;
      io_cs    <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 8'd0;
      io_dout  <= 8'd0;
      bus_err  <= 1'b0;
      we_q     <= 1'b0;
      tcnt     <= 8'd0;
      wcnt     <= 4'd0;
    end else begin
      // strobes last one clk regardless of cen
      io_cs   <= 1'b0;
      bus_err <= 1'b0;
      if (launch) begin
        we_q <= we;
        tcnt <= 8'd0;
        wcnt <= 4'd0;
        case (st_nx)
          ROM: begin rom_cs <= 1'b1; rom_addr <= addr[21:0]; end
          IO: begin
            io_cs   <= 1'b1;
            io_we   <= we;
            io_addr <= addr[7:0];
            io_dout <= cpu_dout;
          end
          ERR: begin
            bus_err <= 1'b1;
            if (!we) cpu_din <= 8'hFF;
          end
          default: ;
        endcase
      end
      if (cen && st == ROM) tcnt <= tcnt_inc;
      if (cen && st == IO)  wcnt <= wcnt + 4'd1;
      if (cen && st == ROM && st_nx != ROM) rom_cs <= 1'b0;
      if (fin) begin
        dtack <= 1'b1;
        case (st)
          RAM: if (!we_q) cpu_din <= ram_q;
          ROM: cpu_din <= rom_data;
          IO:  if (!we_q) cpu_din <= io_din;
          default: ;
        endcase
      end
      if (tout) begin
        dtack   <= 1'b1;
        bus_err <= 1'b1;
        cpu_din <= 8'hFF;
      end
      if (st == DONE && st_nx == IDLE) dtack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtkcpu_bussl.sv
// Directed bench for jtkcpu_bussl: RAM, ROM wait/timeout, I/O, unmapped, abort and reset.
module tb_jtkcpu_bussl;
  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, as = 1'b0, we = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  cpu_dout = '0, cpu_din, rom_data = '0, io_din = '0, io_addr, io_dout;
  logic        dtack, rom_cs, rom_ok = 1'b0, io_cs, io_we, bus_err;
  logic [21:0] rom_addr;
  int tests = 0, fails = 0;

  jtkcpu_bussl #(.RAM_AW(13), .IO_WAIT(2), .TOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .as(as), .addr(addr), .we(we),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack(dtack), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .io_cs(io_cs),
    .io_we(io_we), .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // raise as; returns just after the T0 edge
  task automatic start(input logic [23:0] a, input logic w, input logic [7:0] d);
    as = 1'b1; addr = a; we = w; cpu_dout = d;
    tick();
  endtask

  task automatic finish_acc();
    as = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL rst_dtack got %b exp 0", dtack); end
    tests++; if (cpu_din !== 8'h00) begin fails++; $display("FAIL rst_cpu_din got %h exp 00", cpu_din); end
    tests++; if ({rom_cs, io_cs, bus_err, io_we} !== 4'b0) begin fails++; $display("FAIL rst_strobes got %b exp 0000", {rom_cs, io_cs, bus_err, io_we}); end
    tests++; if (rom_addr !== 22'd0) begin fails++; $display("FAIL rst_rom_addr got %h exp 0", rom_addr); end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_ram();
    start(24'h400123, 1'b1, 8'h5A);
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL ram_wr_t0 got %b exp 0", dtack); end
    tick();
    tests++; if (dtack !== 1'b1) begin fails++; $display("FAIL ram_wr_t1 got %b exp 1", dtack); end
    tests++; if (cpu_din !== 8'h00) begin fails++; $display("FAIL ram_wr_hold got %h exp 00", cpu_din); end
    finish_acc();
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL ram_wr_dtack_fall got %b exp 0", dtack); end
    start(24'h400123, 1'b0, 8'h00);
    tick();
    tests++; if (dtack !== 1'b1) begin fails++; $display("FAIL ram_rd_t1 got %b exp 1", dtack); end
    tests++; if (cpu_din !== 8'h5A) begin fails++; $display("FAIL ram_rd_data got %h exp 5a", cpu_din); end
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL ram_rd_err got %b exp 0", bus_err); end
    finish_acc();
  endtask

  task automatic test_rom_wait();
    rom_data = 8'hC3; rom_ok = 1'b0;
    start(24'h012345, 1'b0, 8'h00);
    tests++; if (rom_cs !== 1'b1) begin fails++; $display("FAIL rom_cs_t0 got %b exp 1", rom_cs); end
    tests++; if (rom_addr !== 22'h012345) begin fails++; $display("FAIL rom_addr got %h exp 012345", rom_addr); end
    tick(); tick(); tick();
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL rom_t3_dtack got %b exp 0", dtack); end
    rom_ok = 1'b1;
    tick();
    tests++; if (dtack !== 1'b1) begin fails++; $display("FAIL rom_t4_dtack got %b exp 1", dtack); end
    tests++; if (cpu_din !== 8'hC3) begin fails++; $display("FAIL rom_data got %h exp c3", cpu_din); end
    tests++; if (rom_cs !== 1'b0) begin fails++; $display("FAIL rom_cs_t4 got %b exp 0", rom_cs); end
    rom_ok = 1'b0;
    finish_acc();
  endtask

  task automatic test_rom_timeout();
    start(24'h000100, 1'b0, 8'h00);
    for (int i = 1; i < 8; i++) tick();
    tests++; if ({dtack, bus_err} !== 2'b00) begin fails++; $display("FAIL tout_t7 got %b exp 00", {dtack, bus_err}); end
    tick();
    tests++; if ({dtack, bus_err, rom_cs} !== 3'b110) begin fails++; $display("FAIL tout_t8 got %b exp 110", {dtack, bus_err, rom_cs}); end
    tests++; if (cpu_din !== 8'hFF) begin fails++; $display("FAIL tout_data got %h exp ff", cpu_din); end
    tick();
    tests++; if ({dtack, bus_err} !== 2'b10) begin fails++; $display("FAIL tout_pulse got %b exp 10", {dtack, bus_err}); end
    finish_acc();
  endtask

  task automatic test_io();
    io_din = 8'h77;
    start(24'h800010, 1'b0, 8'h00);
    tests++; if ({io_cs, io_we} !== 2'b10) begin fails++; $display("FAIL io_rd_t0 got %b exp 10", {io_cs, io_we}); end
    tests++; if (io_addr !== 8'h10) begin fails++; $display("FAIL io_addr got %h exp 10", io_addr); end
    tick();
    tests++; if ({io_cs, dtack} !== 2'b00) begin fails++; $display("FAIL io_rd_t1 got %b exp 00", {io_cs, dtack}); end
    tick();
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL io_rd_t2 got %b exp 0", dtack); end
    tick();
    tests++; if (dtack !== 1'b1) begin fails++; $display("FAIL io_rd_t3 got %b exp 1", dtack); end
    tests++; if (cpu_din !== 8'h77) begin fails++; $display("FAIL io_rd_data got %h exp 77", cpu_din); end
    finish_acc();
    start(24'h800020, 1'b1, 8'h11);
    tests++; if ({io_cs, io_we} !== 2'b11) begin fails++; $display("FAIL io_wr_t0 got %b exp 11", {io_cs, io_we}); end
    tests++; if (io_dout !== 8'h11) begin fails++; $display("FAIL io_dout got %h exp 11", io_dout); end
    tick(); tick(); tick();
    tests++; if (dtack !== 1'b1) begin fails++; $display("FAIL io_wr_t3 got %b exp 1", dtack); end
    tests++; if (cpu_din !== 8'h77) begin fails++; $display("FAIL io_wr_hold got %h exp 77", cpu_din); end
    finish_acc();
  endtask

  task automatic test_unmapped();
    start(24'hC00000, 1'b0, 8'h00);
    tests++; if ({bus_err, rom_cs} !== 2'b10) begin fails++; $display("FAIL unm_rd_t0 got %b exp 10", {bus_err, rom_cs}); end
    tick();
    tests++; if ({dtack, bus_err} !== 2'b10) begin fails++; $display("FAIL unm_rd_t1 got %b exp 10", {dtack, bus_err}); end
    tests++; if (cpu_din !== 8'hFF) begin fails++; $display("FAIL unm_rd_data got %h exp ff", cpu_din); end
    finish_acc();
    start(24'h000010, 1'b1, 8'h33);
    tests++; if ({bus_err, rom_cs} !== 2'b10) begin fails++; $display("FAIL romwr_t0 got %b exp 10", {bus_err, rom_cs}); end
    tick();
    tests++; if ({dtack, bus_err, rom_cs} !== 3'b100) begin fails++; $display("FAIL romwr_t1 got %b exp 100", {dtack, bus_err, rom_cs}); end
    finish_acc();
  endtask

  task automatic test_abort_reset();
    rom_ok = 1'b0;
    start(24'h000200, 1'b0, 8'h00);
    tick();
    as = 1'b0;
    tick();
    tests++; if ({rom_cs, dtack} !== 2'b00) begin fails++; $display("FAIL abort_t2 got %b exp 00", {rom_cs, dtack}); end
    tick();
    tests++; if (dtack !== 1'b0) begin fails++; $display("FAIL abort_after got %b exp 0", dtack); end
    start(24'h400123, 1'b0, 8'h00);
    tick();
    tests++; if ({dtack, cpu_din} !== {1'b1, 8'h5A}) begin fails++; $display("FAIL abort_next got %b/%h exp 1/5a", dtack, cpu_din); end
    finish_acc();
    start(24'h800010, 1'b1, 8'h44);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({io_cs, io_we, dtack, bus_err, rom_cs} !== 5'b0) begin fails++; $display("FAIL rst_mid_io got %b exp 00000", {io_cs, io_we, dtack, bus_err, rom_cs}); end
    tests++; if ({io_addr, io_dout, cpu_din} !== 24'h0) begin fails++; $display("FAIL rst_mid_io_data got %h exp 0", {io_addr, io_dout, cpu_din}); end
    as = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start(24'h400123, 1'b0, 8'h00);
    tick();
    tests++; if ({dtack, cpu_din} !== {1'b1, 8'h5A}) begin fails++; $display("FAIL post_rst_ram got %b/%h exp 1/5a", dtack, cpu_din); end
    finish_acc();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rom_wait();
    test_rom_timeout();
    test_io();
    test_unmapped();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
